// File: rtl/position_ctrl.sv
// position_ctrl: two debounced buttons move a single lit LED left or right along
// an N_POS-wide bar, with optional end wrap-around and hold-to-repeat stepping.
module position_ctrl #(
   parameter int N_POS      = 4,
   parameter int DB_BITS    = 16,
   parameter int WRAP       = 1,
   parameter int REP_EN     = 0,
   parameter int REP_DELAY  = 4194304,
   parameter int REP_PERIOD = 1048576
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [1:0]               buttons,
   output logic [N_POS-1:0]         led,
   output logic [$clog2(N_POS)-1:0] idx,
   output logic                     step,
   output logic                     dir,
   output logic [1:0]               held
);

   localparam int IW = $clog2(N_POS);
   localparam int RW = 25;

   localparam logic [IW-1:0]      IDX_MIN    = {IW{1'b0}};
   localparam logic [IW-1:0]      IDX_MAX    = IW'(N_POS - 1);
   localparam logic [IW-1:0]      IDX_ONE    = IW'(1);
   localparam logic [N_POS-1:0]   LED_HOME   = {{(N_POS-1){1'b0}}, 1'b1};
   localparam logic [RW-1:0]      CNT_ZERO   = {RW{1'b0}};
   localparam logic [RW-1:0]      CNT_ONE    = {{(RW-1){1'b0}}, 1'b1};
   localparam logic [RW-1:0]      DELAY_CNT  = RW'(REP_DELAY);
   localparam logic [RW-1:0]      PERIOD_CNT = RW'(REP_PERIOD);
   localparam logic [DB_BITS-1:0] DB_ZERO    = {DB_BITS{1'b0}};
   localparam logic [DB_BITS-1:0] DB_ONE     = {{(DB_BITS-1){1'b0}}, 1'b1};
   localparam logic [DB_BITS-1:0] DB_FULL    = {DB_BITS{1'b1}};

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DELAY  = 2'd1,
      ST_REPEAT = 2'd2
   } rep_state_t;

   logic [1:0]         meta_r;
   logic [1:0]         sync_r;
   logic [DB_BITS-1:0] db_cnt_r [2];
   logic [1:0]         held_r;
   logic [1:0]         held_prev_r;
   rep_state_t         state_r;
   logic [RW-1:0]      rep_cnt_r;
   logic [N_POS-1:0]   led_r;
   logic [IW-1:0]      idx_r;
   logic               step_r;
   logic               dir_r;

   logic [1:0]         rise_s;
   logic [1:0]         press_s;
   logic               one_held_s;
   logic               req_s;
   logic               req_left_s;
   rep_state_t         state_nx_s;
   logic [RW-1:0]      cnt_nx_s;
   logic               blocked_s;
   logic [N_POS-1:0]   led_nx_s;
   logic [IW-1:0]      idx_nx_s;

   // Two-flop synchronizer; the inversion turns the active-low pins into 1 = pressed.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         meta_r <= 2'b00;
         sync_r <= 2'b00;
      end else begin
         meta_r <= ~buttons;
         sync_r <= meta_r;
      end
   end

   // Per-button debounce: held only follows sync after it has differed for a full counter wrap.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 2; i++) begin
            db_cnt_r[i] <= DB_ZERO;
         end
         held_r <= 2'b00;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (sync_r[i] == held_r[i]) begin
               db_cnt_r[i] <= DB_ZERO;
            end else if (db_cnt_r[i] == DB_FULL) begin
               held_r[i]   <= sync_r[i];
               db_cnt_r[i] <= DB_ZERO;
            end else begin
               db_cnt_r[i] <= db_cnt_r[i] + DB_ONE;
            end
         end
      end
   end

   // Step request and repeat FSM next state; a fresh press edge always restarts the delay.
   always_comb begin
      rise_s     = held_r & ~held_prev_r;
      press_s    = {rise_s[1] & ~held_r[0], rise_s[0] & ~held_r[1]};
      one_held_s = held_r[0] ^ held_r[1];
      req_s      = 1'b0;
      req_left_s = 1'b0;
      state_nx_s = state_r;
      cnt_nx_s   = rep_cnt_r;
      if (press_s != 2'b00) begin
         req_s      = 1'b1;
         req_left_s = press_s[0];
         if (REP_EN != 0) begin
            state_nx_s = ST_DELAY;
            cnt_nx_s   = CNT_ONE;
         end else begin
            state_nx_s = ST_IDLE;
            cnt_nx_s   = CNT_ZERO;
         end
      end else if (!one_held_s || (REP_EN == 0)) begin
         state_nx_s = ST_IDLE;
         cnt_nx_s   = CNT_ZERO;
      end else begin
         case (state_r)
            ST_DELAY: begin
               if (rep_cnt_r == DELAY_CNT) begin
                  req_s      = 1'b1;
                  req_left_s = held_r[0];
                  state_nx_s = ST_REPEAT;
                  cnt_nx_s   = CNT_ONE;
               end else begin
                  cnt_nx_s = rep_cnt_r + CNT_ONE;
               end
            end
            ST_REPEAT: begin
               if (rep_cnt_r == PERIOD_CNT) begin
                  req_s      = 1'b1;
                  req_left_s = held_r[0];
                  cnt_nx_s   = CNT_ONE;
               end else begin
                  cnt_nx_s = rep_cnt_r + CNT_ONE;
               end
            end
            default: begin
               state_nx_s = ST_IDLE;
               cnt_nx_s   = CNT_ZERO;
            end
         endcase
      end
   end

   // Position update; without wrap, a step into the end stop is swallowed.
   always_comb begin
      blocked_s = 1'b0;
      led_nx_s  = led_r;
      idx_nx_s  = idx_r;
      if (WRAP == 0) begin
         if (req_left_s) begin
            blocked_s = (idx_r == IDX_MAX);
         end else begin
            blocked_s = (idx_r == IDX_MIN);
         end
      end else begin
         blocked_s = 1'b0;
      end
      if (req_s && !blocked_s) begin
         if (req_left_s) begin
            led_nx_s = {led_r[N_POS-2:0], led_r[N_POS-1]};
            idx_nx_s = (idx_r == IDX_MAX) ? IDX_MIN : (idx_r + IDX_ONE);
         end else begin
            led_nx_s = {led_r[0], led_r[N_POS-1:1]};
            idx_nx_s = (idx_r == IDX_MIN) ? IDX_MAX : (idx_r - IDX_ONE);
         end
      end else begin
         led_nx_s = led_r;
         idx_nx_s = idx_r;
      end
   end

   // Registered FSM, position and status outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r     <= ST_IDLE;
         rep_cnt_r   <= CNT_ZERO;
         held_prev_r <= 2'b00;
         led_r       <= LED_HOME;
         idx_r       <= IDX_MIN;
         step_r      <= 1'b0;
         dir_r       <= 1'b0;
      end else begin
         state_r     <= state_nx_s;
         rep_cnt_r   <= cnt_nx_s;
         held_prev_r <= held_r;
         led_r       <= led_nx_s;
         idx_r       <= idx_nx_s;
         step_r      <= req_s & ~blocked_s;
         if (req_s) begin
            dir_r <= req_left_s;
         end else begin
            dir_r <= dir_r;
         end
      end
   end

   assign led  = led_r;
   assign idx  = idx_r;
   assign step = step_r;
   assign dir  = dir_r;
   assign held = held_r;

endmodule

// File: tb/tb_position_ctrl.sv
// tb_position_ctrl: directed checks of four position_ctrl configurations sharing
// one clock, reset and button bus (wrap, saturate, auto-repeat, 8 positions).
module tb_position_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] buttons;

   logic [3:0] led_a, led_b, led_c;
   logic [7:0] led_d;
   logic [1:0] idx_a, idx_b, idx_c;
   logic [2:0] idx_d;
   logic       step_a, step_b, step_c, step_d;
   logic       dir_a, dir_b, dir_c, dir_d;
   logic [1:0] held_a, held_b, held_c, held_d;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int cnt_a    = 0;
   int cnt_b    = 0;
   int cnt_c    = 0;
   int cnt_d    = 0;
   int stamp_c [128];

   always #5 clk = ~clk;

   position_ctrl #(.N_POS(4), .DB_BITS(4), .WRAP(1), .REP_EN(0)) u_a (
      .clk(clk), .rst(rst), .buttons(buttons),
      .led(led_a), .idx(idx_a), .step(step_a), .dir(dir_a), .held(held_a));

   position_ctrl #(.N_POS(4), .DB_BITS(4), .WRAP(0), .REP_EN(0)) u_b (
      .clk(clk), .rst(rst), .buttons(buttons),
      .led(led_b), .idx(idx_b), .step(step_b), .dir(dir_b), .held(held_b));

   position_ctrl #(.N_POS(4), .DB_BITS(4), .WRAP(1), .REP_EN(1),
                   .REP_DELAY(20), .REP_PERIOD(5)) u_c (
      .clk(clk), .rst(rst), .buttons(buttons),
      .led(led_c), .idx(idx_c), .step(step_c), .dir(dir_c), .held(held_c));

   position_ctrl #(.N_POS(8), .DB_BITS(4), .WRAP(1), .REP_EN(0)) u_d (
      .clk(clk), .rst(rst), .buttons(buttons),
      .led(led_d), .idx(idx_d), .step(step_d), .dir(dir_d), .held(held_d));

   // Cycle counter plus step-pulse counters; repeat-unit steps are timestamped.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (step_a) cnt_a <= cnt_a + 1;
      if (step_b) cnt_b <= cnt_b + 1;
      if (step_d) cnt_d <= cnt_d + 1;
      if (step_c) begin
         if (cnt_c < 128) stamp_c[cnt_c] <= cyc;
         cnt_c <= cnt_c + 1;
      end
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst     = 1'b0;
      buttons = 2'b11;
      tick(3);
      rst = 1'b1;
   endtask

   initial begin
      int ba, bb, bc, bd, p;
      int rep_off [8];
      rep_off[0] = 0;  rep_off[1] = 20; rep_off[2] = 25; rep_off[3] = 30;
      rep_off[4] = 35; rep_off[5] = 40; rep_off[6] = 45; rep_off[7] = 50;

      // reset state
      rst     = 1'b0;
      buttons = 2'b11;
      tick(3);
      check_val("rst_led_a",  32'(led_a),  32'h1);
      check_val("rst_idx_a",  32'(idx_a),  32'h0);
      check_val("rst_step_a", 32'(step_a), 32'h0);
      check_val("rst_dir_a",  32'(dir_a),  32'h0);
      check_val("rst_held_a", 32'(held_a), 32'h0);
      check_val("rst_held_b", 32'(held_b), 32'h0);
      check_val("rst_held_c", 32'(held_c), 32'h0);
      check_val("rst_led_d",  32'(led_d),  32'h01);
      check_val("rst_held_d", 32'(held_d), 32'h0);
      rst = 1'b1;
      tick(5);

      // 10-cycle glitch on left is filtered out
      ba = cnt_a;
      buttons = 2'b10;
      tick(10);
      buttons = 2'b11;
      tick(40);
      check_val("glitch_led_a",  32'(led_a),      32'h1);
      check_val("glitch_steps",  32'(cnt_a - ba), 32'h0);
      check_val("glitch_held_a", 32'(held_a),     32'h0);

      // single left press held 40 cycles
      apply_reset();
      ba = cnt_a; bb = cnt_b; bd = cnt_d;
      buttons = 2'b10;
      tick(40);
      buttons = 2'b11;
      tick(40);
      check_val("left_led_a",   32'(led_a),      32'h2);
      check_val("left_idx_a",   32'(idx_a),      32'h1);
      check_val("left_dir_a",   32'(dir_a),      32'h1);
      check_val("left_steps_a", 32'(cnt_a - ba), 32'h1);
      check_val("left_led_b",   32'(led_b),      32'h2);
      check_val("left_steps_b", 32'(cnt_b - bb), 32'h1);
      check_val("left_led_d",   32'(led_d),      32'h02);
      check_val("left_steps_d", 32'(cnt_d - bd), 32'h1);

      // right press from home: wraps on a, blocked on b
      apply_reset();
      ba = cnt_a; bb = cnt_b;
      buttons = 2'b01;
      tick(40);
      buttons = 2'b11;
      tick(40);
      check_val("right_led_a",   32'(led_a),      32'h8);
      check_val("right_idx_a",   32'(idx_a),      32'h3);
      check_val("right_dir_a",   32'(dir_a),      32'h0);
      check_val("right_steps_a", 32'(cnt_a - ba), 32'h1);
      check_val("right_led_b",   32'(led_b),      32'h1);
      check_val("right_idx_b",   32'(idx_b),      32'h0);
      check_val("right_steps_b", 32'(cnt_b - bb), 32'h0);
      check_val("right_dir_b",   32'(dir_b),      32'h0);
      check_val("right_led_d",   32'(led_d),      32'h80);
      check_val("right_idx_d",   32'(idx_d),      32'h7);

      // both buttons together for 100 cycles
      apply_reset();
      ba = cnt_a; bc = cnt_c;
      buttons = 2'b00;
      tick(100);
      check_val("both_held_a", 32'(held_a), 32'h3);
      buttons = 2'b11;
      tick(40);
      check_val("both_led_a",   32'(led_a),      32'h1);
      check_val("both_steps_a", 32'(cnt_a - ba), 32'h0);
      check_val("both_steps_c", 32'(cnt_c - bc), 32'h0);
      check_val("both_led_c",   32'(led_c),      32'h1);

      // auto-repeat timing on u_c, then reset while repeating
      apply_reset();
      bc = cnt_c;
      p  = cyc;
      buttons = 2'b10;
      tick(80);
      check_val("rep_count_ge8", 32'(cnt_c - bc >= 8), 32'h1);
      check_val("rep_first_lat", 32'(stamp_c[bc] - p), 32'd19);
      for (int k = 1; k < 8; k++) begin
         check_val($sformatf("rep_off_%0d", k), 32'(stamp_c[bc + k] - stamp_c[bc]), 32'(rep_off[k]));
      end
      rst = 1'b0;
      #1;
      check_val("rep_rst_led_c",  32'(led_c),  32'h1);
      check_val("rep_rst_idx_c",  32'(idx_c),  32'h0);
      check_val("rep_rst_step_c", 32'(step_c), 32'h0);
      check_val("rep_rst_held_c", 32'(held_c), 32'h0);
      tick(3);
      rst = 1'b1;
      bc  = cnt_c;
      tick(18);
      buttons = 2'b11;
      tick(60);
      check_val("rep_after_steps", 32'(cnt_c - bc), 32'h1);
      check_val("rep_after_led_c", 32'(led_c),      32'h2);
      check_val("rep_after_dir_c", 32'(dir_c),      32'h1);

      // eight left presses: full lap on 8 and 4 positions, saturation on u_b
      apply_reset();
      ba = cnt_a; bb = cnt_b; bc = cnt_c; bd = cnt_d;
      repeat (8) begin
         buttons = 2'b10;
         tick(20);
         buttons = 2'b11;
         tick(25);
      end
      check_val("lap_led_d",   32'(led_d),      32'h01);
      check_val("lap_idx_d",   32'(idx_d),      32'h0);
      check_val("lap_steps_d", 32'(cnt_d - bd), 32'd8);
      check_val("lap_dir_d",   32'(dir_d),      32'h1);
      check_val("lap_led_a",   32'(led_a),      32'h1);
      check_val("lap_steps_a", 32'(cnt_a - ba), 32'd8);
      check_val("sat_led_b",   32'(led_b),      32'h8);
      check_val("sat_idx_b",   32'(idx_b),      32'h3);
      check_val("sat_steps_b", 32'(cnt_b - bb), 32'd3);
      check_val("sat_dir_b",   32'(dir_b),      32'h1);
      check_val("lap_steps_c", 32'(cnt_c - bc), 32'd8);
      check_val("lap_led_c",   32'(led_c),      32'h1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/position_ctrl.md
POSITION_CTRL -- requirements
Module: position_ctrl

Interface
REQ-001 SHALL have parameter N_POS, default 4: number of positions and width of led; legal range 2..32.
REQ-002 SHALL have parameter DB_BITS, default 16: debounce counter width; legal range 2..24.
REQ-003 SHALL have parameter WRAP, default 1: 1 = rotate at ends, 0 = saturate at ends.
REQ-004 SHALL have parameter REP_EN, default 0: 1 = auto-repeat while a button is held.
REQ-005 SHALL have parameter REP_DELAY, default 2^22: cycles from a press edge to the first repeat step; legal range 2..2^24.
REQ-006 SHALL have parameter REP_PERIOD, default 2^20: cycles between later repeat steps; legal range 1..2^24.
REQ-007 SHALL have port clk, input, 1 bit: the single clock; all flops on its rising edge.
REQ-008 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-009 SHALL have port buttons, input, 2 bits, asynchronous, active-low: [0] = left, [1] = right.
REQ-010 SHALL have port led, output, N_POS bits: one-hot position.
REQ-011 SHALL have port idx, output, clog2(N_POS) bits: binary index of the set led bit.
REQ-012 SHALL have port step, output, 1 bit: one-cycle pulse in every cycle led changes.
REQ-013 SHALL have port dir, output, 1 bit: direction of the last step; 1 = left.
REQ-014 SHALL have port held, output, 2 bits: debounced pressed state per button.

Function
REQ-015 SHALL pass each button through a 2-flop synchronizer and invert it, so sync = 1 means pressed.
REQ-016 SHALL keep one debounce channel per button: counter cleared while sync == held, incremented while they differ; when the counter is all-ones and still differs, held <= sync and counter <= 0.
REQ-017 SHALL update held in the window 2^DB_BITS .. 2^DB_BITS+3 cycles after a stable input change, and SHALL ignore a glitch shorter than 2^DB_BITS-1 cycles.
REQ-018 SHALL treat a press edge as held rising while the other button is not held.
REQ-019 SHALL, on a left step, rotate led up: led <= {led[N-2:0], led[N-1]}, idx+1, dir <= 1.
REQ-020 SHALL, on a right step, rotate led down: led <= {led[0], led[N-1:1]}, idx-1, dir <= 0.
REQ-021 SHALL, when WRAP=0, make no change to led/idx/step at the end index in the blocked direction, while dir still updates.
REQ-022 SHALL, when WRAP=1, wrap idx modulo N_POS (N-1 -> 0 left, 0 -> N-1 right).
REQ-023 SHALL, when both buttons are held or both rise in the same cycle, produce no step and clear the repeat counter.
REQ-024 SHALL, when REP_EN=1, run a repeat FSM with states IDLE, DELAY and REPEAT:
  - IDLE -> DELAY on a press edge; the step for that edge issues in the same cycle.
  - DELAY -> REPEAT after REP_DELAY cycles with exactly one held button, issuing one step.
  - REPEAT issues one step every REP_PERIOD cycles.
  - Any state -> IDLE on release or when both buttons are held.
REQ-025 SHALL, when REP_EN=0, stay in IDLE and step only on press edges.
REQ-026 SHALL give a step 1 cycle of latency after the held edge (registered); led, idx and step SHALL update in the same cycle.
REQ-027 SHALL keep led exactly one-hot at all times, with idx always consistent with led.

Reset
REQ-028 SHALL, while rst = 0, asynchronously force led = 1 (bit 0), idx = 0, step = 0, dir = 0, held = 0, all counters = 0, FSM = IDLE, synchronizers = 0.
REQ-029 SHALL, after rst is released, detect no press edge until a held bit rises.
REQ-030 SHALL, on rst asserted mid-hold or mid-repeat, abort the repeat immediately, and a button still pressed after release SHALL produce exactly one step once re-debounced.

Verification (DB_BITS=4, N_POS=4 unless stated)
REQ-031 SHALL check: left press held 40 cycles -> exactly one step, led 0001->0010, idx 1, dir 1; with a 10-cycle glitch -> no change.
REQ-032 SHALL check, with WRAP=1: right press from reset -> led 1000, idx 3; with WRAP=0: right press from reset -> led 0001, step never asserted, dir 0.
REQ-033 SHALL check: both buttons pressed in the same cycle for 100 cycles -> no step, led unchanged.
REQ-034 SHALL check, with REP_EN=1, REP_DELAY=20, REP_PERIOD=5: left held 50 cycles past debounce -> steps at t0, t0+20, +25, +30, +35, +40, +45, +50 (8 steps).
REQ-035 SHALL check: rst pulsed low while in REPEAT -> led 0001, FSM IDLE, then one step after re-debounce.
REQ-036 SHALL check, with N_POS=8, WRAP=1: 8 left presses -> led returns to 00000001, idx 0, 8 step pulses.
